// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter and its snoopers (reservation stations, hazard logic).
package cdb_arbiter_pkg;
  localparam int TAG_W_DEF  = 5;
  localparam int DATA_W_DEF = 16;
  localparam int UNIT_ADD   = 0;
  localparam int UNIT_MULT  = 1;
  localparam int UNIT_LOAD  = 2;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += {31'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or after ptr_i, wrapping.
module rr_picker #(
  parameter int NUM_UNITS = 3,
  parameter int PTR_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic [NUM_UNITS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_UNITS-1:0] grant_o,
  output logic [PTR_W-1:0]     idx_o
);
  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      j = (int'(ptr_i) + k) % NUM_UNITS;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = PTR_W'(j);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter with a registered broadcast stage.
// Optional saturating statistics counters are built when CDB_STATS_EN is defined.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_UNITS = 3,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_UNITS-1:0]          req,
  input  logic [NUM_UNITS*TAG_W-1:0]    tag_in,
  input  logic [NUM_UNITS*DATA_W-1:0]   data_in,
  output logic [NUM_UNITS-1:0]          ack,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]             cdb_data,
`ifdef CDB_STATS_EN
  output logic [15:0]                   stat_bcast,
  output logic [15:0]                   stat_conflict,
`endif
  output logic                          busy
);
  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PTR_W-1:0]     ptr_q, ptr_d, g;
  logic [NUM_UNITS-1:0] grant;
  logic                 any_req, conflict, do_grant;
  logic                 valid_q, busy_q;
  logic [TAG_W-1:0]     tag_q;
  logic [DATA_W-1:0]    data_q;

  rr_picker #(.NUM_UNITS(NUM_UNITS), .PTR_W(PTR_W)) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (g)
  );

  // A flush suppresses the grant so no unit retires a result that the bus drops.
  always_comb begin
    any_req  = |req;
    conflict = popcount(32'(req)) > 1;
    do_grant = any_req && !flush;
    ack      = (reset && !flush) ? grant : '0;
    ptr_d    = ptr_q;
    if (flush)         ptr_d = PTR_W'(UNIT_ADD);
    else if (any_req)  ptr_d = (g == PTR_W'(NUM_UNITS - 1)) ? '0 : g + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= do_grant;
      busy_q  <= conflict && !flush;
      if (do_grant) begin
        tag_q  <= tag_in[g*TAG_W +: TAG_W];
        data_q <= data_in[g*DATA_W +: DATA_W];
      end
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign busy      = busy_q;

`ifdef CDB_STATS_EN
  logic [15:0] bcast_q, conf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcast_q <= '0;
      conf_q  <= '0;
    end else if (flush) begin
      bcast_q <= '0;
      conf_q  <= '0;
    end else begin
      if (do_grant && bcast_q != 16'hFFFF) bcast_q <= bcast_q + 16'd1;
      if (conflict && conf_q != 16'hFFFF)  conf_q  <= conf_q + 16'd1;
    end
  end

  assign stat_bcast    = bcast_q;
  assign stat_conflict = conf_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (builds with or without CDB_STATS_EN).
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int TW = 5;
  localparam int DW = 16;

  logic          clock, reset, flush;
  logic [N-1:0]  req, ack;
  logic [N*TW-1:0] tag_in;
  logic [N*DW-1:0] data_in;
  logic          cdb_valid, busy;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
`ifdef CDB_STATS_EN
  logic [15:0]   stat_bcast, stat_conflict;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter #(.NUM_UNITS(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .req       (req),
    .tag_in    (tag_in),
    .data_in   (data_in),
    .ack       (ack),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
`ifdef CDB_STATS_EN
    .stat_bcast    (stat_bcast),
    .stat_conflict (stat_conflict),
`endif
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
    tag_in[u*TW +: TW]  = t;
    data_in[u*DW +: DW] = d;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    req   = 3'b111;
    tag_in  = '0;
    data_in = '0;
    set_unit(0, 5'd1, 16'h1111);
    set_unit(1, 5'd2, 16'h2222);
    set_unit(2, 5'd3, 16'h3333);

    // Reset held with all units requesting
    #3;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_valid", 32'(cdb_valid), 32'h0);
    check("rst_tag", 32'(cdb_tag), 32'h0);
    check("rst_data", 32'(cdb_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    tick();
    tick();
    check("rst_hold_valid", 32'(cdb_valid), 32'h0);
    check("rst_hold_ack", 32'(ack), 32'h0);

    // Release between edges; rotation 001,010,100,001
    #3;
    reset = 1'b1;
    #1;
    check("rr_ack0", 32'(ack), 32'b001);
    tick();
    check("rr_valid0", 32'(cdb_valid), 32'h1);
    check("rr_tag0", 32'(cdb_tag), 32'd1);
    check("rr_data0", 32'(cdb_data), 32'h1111);
    check("rr_busy0", 32'(busy), 32'h1);
    check("rr_ack1", 32'(ack), 32'b010);
    tick();
    check("rr_tag1", 32'(cdb_tag), 32'd2);
    check("rr_data1", 32'(cdb_data), 32'h2222);
    check("rr_busy1", 32'(busy), 32'h1);
    check("rr_ack2", 32'(ack), 32'b100);
    tick();
    check("rr_tag2", 32'(cdb_tag), 32'd3);
    check("rr_busy2", 32'(busy), 32'h1);
    check("rr_ack_wrap", 32'(ack), 32'b001);
    tick();
    check("rr_tag3", 32'(cdb_tag), 32'd1);
    check("rr_valid3", 32'(cdb_valid), 32'h1);

    // Multiplier alone (pointer now 1)
    req = 3'b010;
    set_unit(1, 5'b00100, 16'h00AB);
    #1;
    check("mul_ack", 32'(ack), 32'b010);
    tick();
    check("mul_valid", 32'(cdb_valid), 32'h1);
    check("mul_tag", 32'(cdb_tag), 32'd4);
    check("mul_data", 32'(cdb_data), 32'h00AB);
    check("mul_busy", 32'(busy), 32'h0);

    // Single-cycle pulse from adder (pointer 2 wraps to unit 0)
    req = 3'b001;
    #1;
    check("pulse_ack", 32'(ack), 32'b001);
    tick();
    check("pulse_valid", 32'(cdb_valid), 32'h1);
    check("pulse_tag", 32'(cdb_tag), 32'd1);
    req = 3'b000;
    #1;
    check("idle_ack", 32'(ack), 32'h0);
    tick();
    check("idle_valid", 32'(cdb_valid), 32'h0);
    check("idle_tag_hold", 32'(cdb_tag), 32'd1);
    check("idle_data_hold", 32'(cdb_data), 32'h1111);
    check("idle_busy", 32'(busy), 32'h0);
    // Pointer should be 1: 101 grants unit 2, not unit 0
    req = 3'b101;
    #1;
    check("ptr1_ack", 32'(ack), 32'b100);

    // Move pointer to 2 with contention, then flush
    req = 3'b011;
    #1;
    check("pre_flush_ack", 32'(ack), 32'b010);
    tick();
    check("pre_flush_busy", 32'(busy), 32'h1);
    flush = 1'b1;
    req   = 3'b110;
    #1;
    check("flush_ack", 32'(ack), 32'h0);
    tick();
    check("flush_valid", 32'(cdb_valid), 32'h0);
    check("flush_busy", 32'(busy), 32'h0);
    flush = 1'b0;
    #1;
    check("post_flush_ack", 32'(ack), 32'b010);
    tick();
    check("post_flush_valid", 32'(cdb_valid), 32'h1);
    check("post_flush_tag", 32'(cdb_tag), 32'd4);
    check("post_flush_busy", 32'(busy), 32'h1);
`ifdef CDB_STATS_EN
    check("stat_bcast_pre", 32'(stat_bcast), 32'd1);
    check("stat_conf_pre", 32'(stat_conflict), 32'd1);
`endif

    // Asynchronous reset mid-cycle while the bus is valid
    #3;
    reset = 1'b0;
    #1;
    check("async_valid", 32'(cdb_valid), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_tag", 32'(cdb_tag), 32'h0);
    check("async_ack", 32'(ack), 32'h0);
`ifdef CDB_STATS_EN
    check("async_stat_bcast", 32'(stat_bcast), 32'h0);
    check("async_stat_conf", 32'(stat_conflict), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
